// File: rtl/demux_pkg.sv
// Shared select encoding and types for the 1-to-4 demultiplexer.
package demux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_Y0 = 2'b00;
  localparam sel_t SEL_Y1 = 2'b01;
  localparam sel_t SEL_Y2 = 2'b10;
  localparam sel_t SEL_Y3 = 2'b11;

endpackage

// File: rtl/demux_decode_2to4.sv
// Combinational 2-to-4 one-hot decoder; an unknown select yields no enables.
module demux_decode_2to4
  import demux_pkg::*;
(
  input  sel_t       sel,
  output logic [3:0] en
);

  always_comb begin
    en = '0;
    case (sel)
      SEL_Y0:  en = 4'b0001;
      SEL_Y1:  en = 4'b0010;
      SEL_Y2:  en = 4'b0100;
      SEL_Y3:  en = 4'b1000;
      default: en = '0;
    endcase
  end

endmodule

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer: din steered to one of y0..y3, unselected outputs held at zero.
// Output stage is either a reset-cleared register or a combinational pass-through.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH      = 1,
  parameter bit          REGISTERED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3
);

  logic [3:0]            en;
  logic [3:0][WIDTH-1:0] lane_d;
  logic [3:0][WIDTH-1:0] lane_out;

  demux_decode_2to4 u_decode (
    .sel (sel),
    .en  (en)
  );

  always_comb begin
    lane_d = '0;
    for (int i = 0; i < 4; i++) begin
      lane_d[i] = en[i] ? din : '0;
    end
  end

  if (REGISTERED) begin : gen_reg
    logic [3:0][WIDTH-1:0] lane_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign lane_out = lane_q;
  end else begin : gen_comb
    assign lane_out = lane_d;
  end

  assign y0 = lane_out[0];
  assign y1 = lane_out[1];
  assign y2 = lane_out[2];
  assign y3 = lane_out[3];

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown(sel))
        else $error("demux_1to4: sel is unknown outside reset");
    end
    assert ($onehot0({|y3, |y2, |y1, |y0}))
      else $error("demux_1to4: more than one output active");
  end
`endif

endmodule

// File: tb/tb_demux_1to4.sv
// Scoreboard bench for demux_1to4: registered 1-bit and 8-bit instances plus a combinational one.
module tb_demux_1to4;
  import demux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  sel_t       sel;
  logic       din1;
  logic [7:0] din8;

  logic       r1_y0, r1_y1, r1_y2, r1_y3;
  logic [7:0] r8_y0, r8_y1, r8_y2, r8_y3;
  logic [7:0] c_y0, c_y1, c_y2, c_y3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0]  e1;
    logic [31:0] e8;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  demux_1to4 #(.WIDTH(1), .REGISTERED(1'b1)) u_reg1 (
    .clk (clk), .rst (rst), .din (din1), .sel (sel),
    .y0 (r1_y0), .y1 (r1_y1), .y2 (r1_y2), .y3 (r1_y3)
  );

  demux_1to4 #(.WIDTH(8), .REGISTERED(1'b1)) u_reg8 (
    .clk (clk), .rst (rst), .din (din8), .sel (sel),
    .y0 (r8_y0), .y1 (r8_y1), .y2 (r8_y2), .y3 (r8_y3)
  );

  demux_1to4 #(.WIDTH(8), .REGISTERED(1'b0)) u_comb8 (
    .clk (clk), .rst (rst), .din (din8), .sel (sel),
    .y0 (c_y0), .y1 (c_y1), .y2 (c_y2), .y3 (c_y3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: lane k (y0 first, most significant) carries din iff sel selects k.
  function automatic logic [31:0] model8(input logic [1:0] s, input logic [7:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(s) == k) r[31-8*k -: 8] = d;
    end
    return r;
  endfunction

  function automatic logic [3:0] model1(input logic [1:0] s, input logic d);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(s) == k) r[3-k] = d;
    end
    return r;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.e1 = model1(sel, din1);
    e.e8 = model8(sel, din8);
    q.push_back(e);
  endtask

  task automatic drive(input logic d1, input logic [7:0] d8, input logic [1:0] s);
    @(negedge clk);
    din1 = d1;
    din8 = d8;
    sel  = s;
    push_exp();
    #1;
    check("comb_follow", {c_y0, c_y1, c_y2, c_y3}, model8(s, d8));
  endtask

  // Monitor: each edge that captured a driven item presents its result just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("reg1_out", {28'b0, r1_y0, r1_y1, r1_y2, r1_y3}, {28'b0, e.e1});
      check("reg8_out", {r8_y0, r8_y1, r8_y2, r8_y3}, e.e8);
    end
  end

  initial begin
    logic       rd1;
    logic [7:0] rd8;
    logic [1:0] rs;

    rst  = 1'b1;
    din1 = 1'b1;
    sel  = 2'b10;
    din8 = 8'h5a;
    #1;
    check("rst_imm_r1", {28'b0, r1_y0, r1_y1, r1_y2, r1_y3}, 32'h0);
    check("rst_imm_r8", {r8_y0, r8_y1, r8_y2, r8_y3}, 32'h0);
    check("comb_in_rst", {c_y0, c_y1, c_y2, c_y3}, 32'h00005a00);

    repeat (2) @(negedge clk);
    check("rst_hold_r1", {28'b0, r1_y0, r1_y1, r1_y2, r1_y3}, 32'h0);
    check("rst_hold_r8", {r8_y0, r8_y1, r8_y2, r8_y3}, 32'h0);

    // Release: the first edge after deassertion samples din=1, sel=10.
    @(negedge clk);
    rst = 1'b0;
    push_exp();

    for (int s = 0; s < 4; s++) drive(1'b1, 8'hff, 2'(s));
    for (int s = 0; s < 4; s++) drive(1'b0, 8'h00, 2'(s));

    drive(1'b1, 8'ha5, 2'b01);
    drive(1'b0, 8'h3c, 2'b11);

    // Reset pulse between edges while y3 is active.
    drive(1'b1, 8'h77, 2'b11);
    @(posedge clk);
    #3;
    check("pre_pulse_r1", {28'b0, r1_y0, r1_y1, r1_y2, r1_y3}, 32'h1);
    rst = 1'b1;
    #1;
    check("pulse_r1", {28'b0, r1_y0, r1_y1, r1_y2, r1_y3}, 32'h0);
    check("pulse_r8", {r8_y0, r8_y1, r8_y2, r8_y3}, 32'h0);
    check("pulse_comb", {c_y0, c_y1, c_y2, c_y3}, model8(sel, din8));
    rst = 1'b0;
    #1;
    check("post_pulse_r1", {28'b0, r1_y0, r1_y1, r1_y2, r1_y3}, 32'h0);
    push_exp();

    repeat (300) begin
      rd1 = 1'($urandom);
      rd8 = 8'($urandom);
      rs  = 2'($urandom);
      drive(rd1, rd8, rs);
    end

    repeat (2) @(negedge clk);
    check("drain", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
